// File: rtl/game_over_ctrl.sv
// rtl/game_over_ctrl.sv - game-state controller producing the end-screen hit level
//
// Purpose:
//   Tracks IDLE / RUN / OVER game states. It checks once per frame whether the
//   goose and obstacle bounding boxes overlap, and latches game-over when they
//   do. While in OVER, the jump button is ignored for LOCKOUT_FRAMES frames.
//   After that, a button press restarts the game.
//
// Optional feature (macro GAME_OVER_BLINK_EN):
//   When defined, blink toggles every BLINK_FRAMES frames while in OVER until
//   the lockout expires, and then holds at 1. When undefined, blink is tied
//   to 1 and no blink counter is built.
//
// Ports:
//   clk           in   system/pixel clock
//   reset         in   asynchronous active-high reset
//   frame_tick    in   one-cycle pulse per frame (start of vertical blank)
//   btn_jump      in   jump button level, already synchronised to clk
//   goose_x/y     in   [9:0] goose box left/top edge
//   obs_x/y       in   [9:0] obstacle box left/top edge
//   hit           out  high while in OVER (overlay hit input)
//   running       out  high while in RUN
//   restart_pulse out  one-cycle pulse as running first goes high
//   blink         out  restart-arrow blink enable

module game_over_ctrl #(
    parameter int GOOSE_W        = 16,
    parameter int GOOSE_H        = 20,
    parameter int OBS_W          = 12,
    parameter int OBS_H          = 24,
    parameter int LOCKOUT_FRAMES = 30,
    parameter int BLINK_FRAMES   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_jump,
    input  logic [9:0] goose_x,
    input  logic [9:0] goose_y,
    input  logic [9:0] obs_x,
    input  logic [9:0] obs_y,
    output logic       hit,
    output logic       running,
    output logic       restart_pulse,
    output logic       blink
);

    // Elaboration-time parameter range checks
    if (LOCKOUT_FRAMES < 1 || LOCKOUT_FRAMES > 255) begin : gBadLockout
        $error("LOCKOUT_FRAMES out of range 1..255");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : gBadBlink
        $error("BLINK_FRAMES out of range 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } stateT;

    localparam logic [10:0] gooseW11   = 11'(GOOSE_W);
    localparam logic [10:0] gooseH11   = 11'(GOOSE_H);
    localparam logic [10:0] obsW11     = 11'(OBS_W);
    localparam logic [10:0] obsH11     = 11'(OBS_H);
    localparam logic [7:0]  lockoutMax = 8'(LOCKOUT_FRAMES);

    stateT      state;
    logic       btnPrev;
    logic [7:0] frameCnt;

    logic       press;
    logic       lockoutDone;
    logic       lockoutNext;

    // Zero-extend the positions to 11 bits, so that adding a box size to a
    // position near 1023 cannot wrap back to a small value.
    logic [10:0] gx11, gy11, ox11, oy11;
    logic [10:0] gxEnd, gyEnd, oxEnd, oyEnd;
    logic        overlap;

    assign gx11  = {1'b0, goose_x};
    assign gy11  = {1'b0, goose_y};
    assign ox11  = {1'b0, obs_x};
    assign oy11  = {1'b0, obs_y};
    assign gxEnd = gx11 + gooseW11;
    assign gyEnd = gy11 + gooseH11;
    assign oxEnd = ox11 + obsW11;
    assign oyEnd = oy11 + obsH11;

    // Strict compares: boxes whose edges only touch do not overlap.
    assign overlap = (gx11 < oxEnd) & (ox11 < gxEnd) &
                     (gy11 < oyEnd) & (oy11 < gyEnd);

    assign press       = btn_jump & ~btnPrev;
    assign lockoutDone = (frameCnt == lockoutMax);
    // The next frame tick is the one that finishes the lockout.
    assign lockoutNext = (frameCnt == lockoutMax - 8'd1);

`ifdef GAME_OVER_BLINK_EN
    localparam logic [7:0] blinkLast = 8'(BLINK_FRAMES - 1);
    logic       blinkReg;
    logic [7:0] blinkCnt;
    assign blink = blinkReg;
`else
    assign blink = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hit           <= 1'b0;
            running       <= 1'b0;
            restart_pulse <= 1'b0;
            btnPrev       <= 1'b0;
            frameCnt      <= 8'd0;
`ifdef GAME_OVER_BLINK_EN
            blinkReg      <= 1'b1;
            blinkCnt      <= 8'd0;
`endif
        end else begin
            btnPrev       <= btn_jump;
            restart_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    hit     <= 1'b0;
                    running <= 1'b0;
                    if (press) begin
                        state         <= RUN;
                        running       <= 1'b1;
                        restart_pulse <= 1'b1;
                    end
                end

                RUN: begin
                    hit     <= 1'b0;
                    running <= 1'b1;
                    // A collision on this frame takes priority over a press.
                    if (frame_tick && overlap) begin
                        state    <= OVER;
                        hit      <= 1'b1;
                        running  <= 1'b0;
                        frameCnt <= 8'd0;
`ifdef GAME_OVER_BLINK_EN
                        blinkReg <= 1'b1;
                        blinkCnt <= 8'd0;
`endif
                    end
                end

                OVER: begin
                    hit     <= 1'b1;
                    running <= 1'b0;
                    // A qualifying press wins over a frame tick in the same cycle.
                    if (press && lockoutDone) begin
                        state         <= RUN;
                        hit           <= 1'b0;
                        running       <= 1'b1;
                        restart_pulse <= 1'b1;
`ifdef GAME_OVER_BLINK_EN
                        blinkReg      <= 1'b1;
`endif
                    end else if (frame_tick) begin
                        if (!lockoutDone) begin
                            frameCnt <= frameCnt + 8'd1;
                        end
`ifdef GAME_OVER_BLINK_EN
                        // Once the lockout is over, the arrow stays steady.
                        if (lockoutDone || lockoutNext) begin
                            blinkReg <= 1'b1;
                        end else if (blinkCnt == blinkLast) begin
                            blinkReg <= ~blinkReg;
                            blinkCnt <= 8'd0;
                        end else begin
                            blinkCnt <= blinkCnt + 8'd1;
                        end
`endif
                    end
                end

                default: begin
                    state   <= IDLE;
                    hit     <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifndef GAME_OVER_BLINK_EN
    // lockoutNext only drives the optional blink logic.
    logic unusedLockoutNext;
    assign unusedLockoutNext = lockoutNext;
`endif

endmodule

// File: tb/tb_game_over_ctrl.sv
// tb/tb_game_over_ctrl.sv - randomized self-checking bench for game_over_ctrl

module tb_game_over_ctrl;

    localparam int GW   = 16;
    localparam int GH   = 20;
    localparam int OW   = 12;
    localparam int OH   = 24;
    localparam int LOCK = 30;
    localparam int BLNK = 15;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OVER = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn_jump;
    logic [9:0] goose_x, goose_y, obs_x, obs_y;
    logic       hit, running, restart_pulse, blink;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    int mMode;
    int mTicks;       // frame ticks seen since entering OVER (not saturated)
    bit mPrev;
    bit mPulse;

    game_over_ctrl #(
        .GOOSE_W(GW), .GOOSE_H(GH), .OBS_W(OW), .OBS_H(OH),
        .LOCKOUT_FRAMES(LOCK), .BLINK_FRAMES(BLNK)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_jump(btn_jump),
        .goose_x(goose_x), .goose_y(goose_y), .obs_x(obs_x), .obs_y(obs_y),
        .hit(hit), .running(running), .restart_pulse(restart_pulse), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit expBlink();
`ifdef GAME_OVER_BLINK_EN
        if (mMode == M_OVER && mTicks < LOCK)
            return ((mTicks / BLNK) % 2) == 0;
        return 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void modelReset();
        mMode  = M_IDLE;
        mTicks = 0;
        mPrev  = 1'b0;
        mPulse = 1'b0;
    endfunction

    // One clock of game rules, with the inputs that are applied before the edge.
    function automatic void modelClock(input bit ft, input bit btn,
                                       input int gx, input int gy, input int ox, input int oy);
        bit press;
        bit boxesMeet;
        press     = btn && !mPrev;
        mPrev     = btn;
        mPulse    = 1'b0;
        boxesMeet = (gx < ox + OW) && (ox < gx + GW) && (gy < oy + OH) && (oy < gy + GH);
        if (mMode == M_IDLE) begin
            if (press) begin mMode = M_RUN; mPulse = 1'b1; end
        end else if (mMode == M_RUN) begin
            if (ft && boxesMeet) begin mMode = M_OVER; mTicks = 0; end
        end else begin
            if (press && mTicks >= LOCK) begin mMode = M_RUN; mPulse = 1'b1; end
            else if (ft) mTicks++;
        end
    endfunction

    task automatic checkOutputs(input string tag);
        checkEq({tag, ".hit"},     {31'd0, hit},           {31'd0, mMode == M_OVER});
        checkEq({tag, ".running"}, {31'd0, running},       {31'd0, mMode == M_RUN});
        checkEq({tag, ".pulse"},   {31'd0, restart_pulse}, {31'd0, mPulse});
        checkEq({tag, ".blink"},   {31'd0, blink},         {31'd0, expBlink()});
    endtask

    task automatic step(input string tag, input bit ft, input bit btn,
                        input int gx, input int gy, input int ox, input int oy);
        @(negedge clk);
        frame_tick = ft;
        btn_jump   = btn;
        goose_x    = 10'(gx);
        goose_y    = 10'(gy);
        obs_x      = 10'(ox);
        obs_y      = 10'(oy);
        modelClock(ft, btn, gx, gy, ox, oy);
        @(posedge clk);
        #1;
        checkOutputs(tag);
    endtask

    // Assert reset between edges and check that the outputs clear without a clock edge.
    task automatic midCycleReset(input string tag);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkEq({tag, ".hit"},     {31'd0, hit},           32'd0);
        checkEq({tag, ".running"}, {31'd0, running},       32'd0);
        checkEq({tag, ".pulse"},   {31'd0, restart_pulse}, 32'd0);
        checkEq({tag, ".blink"},   {31'd0, blink},         32'd1);
        modelReset();
        frame_tick = 1'b0;
        btn_jump   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        bit ft, btn;
        int gx, gy, ox, oy;

        reset = 1'b1; frame_tick = 1'b0; btn_jump = 1'b0;
        goose_x = '0; goose_y = '0; obs_x = 10'd500; obs_y = 10'd500;
        modelReset();
        #2;
        checkEq("rst.hit",     {31'd0, hit},           32'd0);
        checkEq("rst.running", {31'd0, running},       32'd0);
        checkEq("rst.pulse",   {31'd0, restart_pulse}, 32'd0);
        checkEq("rst.blink",   {31'd0, blink},         32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Start: button held for three cycles yields a single pulse.
        pulses = 0;
        step("start0", 1'b0, 1'b1, 100, 200, 500, 500);
        checkEq("start.running", {31'd0, running}, 32'd1);
        pulses += int'(restart_pulse);
        step("start1", 1'b1, 1'b1, 100, 200, 500, 500);
        pulses += int'(restart_pulse);
        step("start2", 1'b0, 1'b1, 100, 200, 500, 500);
        pulses += int'(restart_pulse);
        checkEq("start.pulses", pulses, 32'd1);
        step("release", 1'b0, 1'b0, 100, 200, 500, 500);

        // Touching edge, then a real overlap.
        step("touch", 1'b1, 1'b0, 100, 200, 116, 210);
        checkEq("touch.hit", {31'd0, hit}, 32'd0);
        step("coll", 1'b1, 1'b0, 100, 200, 110, 210);
        checkEq("coll.hit", {31'd0, hit}, 32'd1);

        // Lockout: 29 ticks, then press ignored; 30th tick, then press restarts.
        for (int i = 0; i < LOCK - 1; i++) step("lock_tick", 1'b1, 1'b0, 100, 200, 110, 210);
        step("early_press", 1'b0, 1'b1, 100, 200, 110, 210);
        checkEq("early.hit", {31'd0, hit}, 32'd1);
        step("early_rel", 1'b0, 1'b0, 100, 200, 110, 210);
        step("tick30", 1'b1, 1'b0, 100, 200, 110, 210);
        step("late_press", 1'b0, 1'b1, 100, 200, 110, 210);
        checkEq("late.pulse",   {31'd0, restart_pulse}, 32'd1);
        checkEq("late.running", {31'd0, running},       32'd1);
        step("late_rel", 1'b0, 1'b0, 100, 200, 110, 210);

        // Priority: overlap without a tick does nothing; tick+overlap beats a press.
        step("no_tick", 1'b0, 1'b0, 100, 200, 110, 210);
        checkEq("no_tick.running", {31'd0, running}, 32'd1);
        step("prio", 1'b1, 1'b1, 100, 200, 110, 210);
        checkEq("prio.hit",   {31'd0, hit},           32'd1);
        checkEq("prio.pulse", {31'd0, restart_pulse}, 32'd0);
        step("prio_rel", 1'b1, 1'b0, 100, 200, 110, 210);

        // Asynchronous reset while in OVER.
        midCycleReset("rst_over");

        // Randomized phase: boxes kept close so that collisions are frequent.
        btn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) midCycleReset("rst_rand");
            ft  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) btn = ~btn;
            gx  = int'($urandom_range(0, 1023));
            gy  = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) begin
                ox = (gx + int'($urandom_range(0, 48)) - 24) & 1023;
                oy = (gy + int'($urandom_range(0, 56)) - 28) & 1023;
            end else begin
                ox = (gx + int'($urandom_range(0, 80)) - 40) & 1023;
                oy = (gy + 512) & 1023;
            end
            step("rand", ft, btn, gx, gy, ox, oy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
